// File: rtl/instr_decode_queue.sv
// instr_decode_queue: registered RV32I decoder feeding a QDEPTH-entry FIFO of decoded instructions.
// Define ID_RV32M_EN to decode the M extension; otherwise those encodings are flagged illegal.
module instr_decode_queue #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4,
  parameter int PCW    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [PCW-1:0]            in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PCW-1:0]            out_pc,
  output logic [XLEN-1:0]           out_imm,
  output logic [3:0]                out_alu_op,
  output logic [2:0]                out_cmp_op,
  output logic [4:0]                out_rd,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic                      out_reg_we,
  output logic                      out_d1_sel,
  output logic                      out_d2_sel,
  output logic [1:0]                out_mem_op,
  output logic [2:0]                out_mem_sel,
  output logic [1:0]                out_wb_sel,
  output logic                      out_jump,
  output logic                      out_trap,
  output logic                      out_illegal,
  output logic [$clog2(QDEPTH):0]   out_count
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_SLL = 4'h2, ALU_XOR = 4'h3,
                         ALU_SRL = 4'h4, ALU_SRA = 4'h5, ALU_OR  = 4'h6, ALU_AND = 4'h7;
  localparam logic [2:0] CMP_NOP = 3'd0, CMP_LT = 3'd3, CMP_LTU = 3'd5;
  localparam logic       D1_PC = 1'b1, D2_IMM = 1'b1;
  localparam logic [1:0] MEM_LOAD = 2'd1, MEM_STORE = 2'd2;
  localparam logic [1:0] WB_MEM = 2'd1, WB_IMM = 2'd2, WB_PC_NEXT = 2'd3;

  typedef struct packed {
    logic [PCW-1:0]  pc;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [2:0]      cmp_op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            reg_we;
    logic            d1_sel;
    logic            d2_sel;
    logic [1:0]      mem_op;
    logic [2:0]      mem_sel;
    logic [1:0]      wb_sel;
    logic            jump;
    logic            trap;
    logic            illegal;
  } entry_t;

  // SLT/SLTU reuse the branch comparator: a writing instruction with a non-NOP cmp_op writes the compare bit.
  function automatic logic [6:0] alu_cmp(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    alu_cmp = {alt ? ALU_SUB : ALU_ADD, CMP_NOP};
      3'd1:    alu_cmp = {ALU_SLL, CMP_NOP};
      3'd2:    alu_cmp = {ALU_SUB, CMP_LT};
      3'd3:    alu_cmp = {ALU_SUB, CMP_LTU};
      3'd4:    alu_cmp = {ALU_XOR, CMP_NOP};
      3'd5:    alu_cmp = {alt ? ALU_SRA : ALU_SRL, CMP_NOP};
      3'd6:    alu_cmp = {ALU_OR, CMP_NOP};
      default: alu_cmp = {ALU_AND, CMP_NOP};
    endcase
  endfunction

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1f, rs2f;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            has_rd, bad;
  entry_t          d, head;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rs1f  = in_instr[19:15];
  assign rs2f  = in_instr[24:20];
  assign imm_i = {{21{in_instr[31]}}, in_instr[30:20]};
  assign imm_s = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    d = '0;
    d.pc = in_pc;
    has_rd = 1'b0;
    bad = 1'b0;
    case (opc)
      7'b0110111: begin
        d.imm = imm_u;
        d.d2_sel = D2_IMM;
        d.wb_sel = WB_IMM;
        has_rd = 1'b1;
      end
      7'b0010111: begin
        d.imm = imm_u;
        d.d1_sel = D1_PC;
        d.d2_sel = D2_IMM;
        has_rd = 1'b1;
      end
      7'b1101111: begin
        d.imm = imm_j;
        d.d1_sel = D1_PC;
        d.d2_sel = D2_IMM;
        d.wb_sel = WB_PC_NEXT;
        d.jump = 1'b1;
        has_rd = 1'b1;
      end
      7'b1100111: begin
        d.imm = imm_i;
        d.rs1 = rs1f;
        d.d2_sel = D2_IMM;
        d.wb_sel = WB_PC_NEXT;
        d.jump = 1'b1;
        has_rd = 1'b1;
        bad = f3 != 3'd0;
      end
      7'b1100011: begin
        d.imm = imm_b;
        d.rs1 = rs1f;
        d.rs2 = rs2f;
        d.d1_sel = D1_PC;
        d.d2_sel = D2_IMM;
        d.cmp_op = f3[2] ? f3 - 3'd1 : f3 + 3'd1;
        bad = f3[2:1] == 2'b01;
      end
      7'b0000011: begin
        d.imm = imm_i;
        d.rs1 = rs1f;
        d.d2_sel = D2_IMM;
        d.mem_op = MEM_LOAD;
        d.mem_sel = f3;
        d.wb_sel = WB_MEM;
        has_rd = 1'b1;
        bad = f3[1:0] == 2'b11 || f3 == 3'd6;
      end
      7'b0100011: begin
        d.imm = imm_s;
        d.rs1 = rs1f;
        d.rs2 = rs2f;
        d.d2_sel = D2_IMM;
        d.mem_op = MEM_STORE;
        d.mem_sel = f3;
        bad = f3 > 3'd2;
      end
      7'b0010011: begin
        d.imm = imm_i;
        d.rs1 = rs1f;
        d.d2_sel = D2_IMM;
        has_rd = 1'b1;
        {d.alu_op, d.cmp_op} = alu_cmp(f3, f3 == 3'd5 && f7[5]);
        bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'b0110011: begin
        d.rs1 = rs1f;
        d.rs2 = rs2f;
        has_rd = 1'b1;
        {d.alu_op, d.cmp_op} = alu_cmp(f3, f7[5]);
        if (f7 == 7'h01) begin
`ifdef ID_RV32M_EN
          d.alu_op = {1'b1, f3};
          d.cmp_op = CMP_NOP;
`else
          bad = 1'b1;
`endif
        end else if (f7 == 7'h20) bad = f3 != 3'd0 && f3 != 3'd5;
        else bad = f7 != 7'h00;
      end
      7'b0001111: ;
      7'b1110011: begin
        d.imm = imm_i;
        d.trap = 1'b1;
        bad = in_instr[31:21] != '0 || in_instr[19:7] != '0;
      end
      default: bad = 1'b1;
    endcase
    d.rd = has_rd ? in_instr[11:7] : '0;
    d.reg_we = has_rd && in_instr[11:7] != 5'd0;
    if (bad) begin
      d = '0;
      d.pc = in_pc;
      d.illegal = 1'b1;
    end
  end

  entry_t        mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enq, deq;

  assign in_ready  = cnt_q != CW'(QDEPTH);
  assign out_valid = cnt_q != '0;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(enq);
    rd_ptr_d = rd_ptr_q + AW'(deq);
    cnt_d = cnt_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= d;
  end

  assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_pc      = head.pc;
  assign out_imm     = head.imm;
  assign out_alu_op  = head.alu_op;
  assign out_cmp_op  = head.cmp_op;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_reg_we  = head.reg_we;
  assign out_d1_sel  = head.d1_sel;
  assign out_d2_sel  = head.d2_sel;
  assign out_mem_op  = head.mem_op;
  assign out_mem_sel = head.mem_sel;
  assign out_wb_sel  = head.wb_sel;
  assign out_jump    = head.jump;
  assign out_trap    = head.trap;
  assign out_illegal = head.illegal;
  assign out_count   = cnt_q;
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: directed vectors with hand-computed decode fields and FIFO occupancy.
module tb_instr_decode_queue;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, out_pc, out_imm;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_cmp_op, out_mem_sel, out_count;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_reg_we, out_d1_sel, out_d2_sel, out_jump, out_trap, out_illegal;
  logic [1:0]  out_mem_op, out_wb_sel;
  int          n_chk = 0, n_bad = 0;

  instr_decode_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_cmp_op(out_cmp_op), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_reg_we(out_reg_we), .out_d1_sel(out_d1_sel), .out_d2_sel(out_d2_sel),
    .out_mem_op(out_mem_op), .out_mem_sel(out_mem_sel), .out_wb_sel(out_wb_sel),
    .out_jump(out_jump), .out_trap(out_trap), .out_illegal(out_illegal), .out_count(out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_count", 32'(out_count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_imm", out_imm, 0);
    rst = 1'b0;
    // addi x5,x0,-1 with execute ready
    out_ready = 1'b1;
    send(32'hFFF00293, 32'h100);
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_rd", 32'(out_rd), 5);
    chk("addi_rs1", 32'(out_rs1), 0);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_d2", 32'(out_d2_sel), 1);
    chk("addi_we", 32'(out_reg_we), 1);
    chk("addi_alu", 32'(out_alu_op), 0);
    chk("addi_pc", out_pc, 32'h100);
    tick();
    out_ready = 1'b0;
    chk("addi_drained", 32'(out_count), 0);
    // fill past capacity
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = 32'hFFF00293;
      in_pc = 32'h200 + 32'(4 * i);
      chk("fill_ready", 32'(in_ready), 32'(i < 4));
      tick();
    end
    chk("full_count", 32'(out_count), 4);
    chk("full_ready", 32'(in_ready), 0);
    in_pc = 32'h300;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("full_deq_count", 32'(out_count), 3);
    for (int i = 1; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'h200 + 32'(4 * i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(out_count), 0);
    chk("drain_valid", 32'(out_valid), 0);
    // flush beats a same-cycle enqueue and dequeue
    send(32'hFFF00293, 32'h400);
    send(32'hFFF00293, 32'h404);
    chk("pre_flush_count", 32'(out_count), 2);
    flush = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("flush_count", 32'(out_count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_pc", out_pc, 0);
    chk("flush_rd", 32'(out_rd), 0);
    chk("flush_imm", out_imm, 0);
    chk("flush_ready", 32'(in_ready), 1);
    // sw x2,8(x1)
    send(32'h0020A423, 32'h500);
    chk("sw_mem", 32'(out_mem_op), 2);
    chk("sw_imm", out_imm, 8);
    chk("sw_we", 32'(out_reg_we), 0);
    chk("sw_rd", 32'(out_rd), 0);
    chk("sw_rs2", 32'(out_rs2), 2);
    chk("sw_sel", 32'(out_mem_sel), 2);
    pop();
    send(32'h0000707F, 32'h504);
    chk("unk_ill", 32'(out_illegal), 1);
    chk("unk_we", 32'(out_reg_we), 0);
    chk("unk_mem", 32'(out_mem_op), 0);
    pop();
    send(32'h022081B3, 32'h508);
`ifdef ID_RV32M_EN
    chk("mul_ill", 32'(out_illegal), 0);
    chk("mul_alu", 32'(out_alu_op), 8);
    chk("mul_rd", 32'(out_rd), 3);
`else
    chk("mul_ill", 32'(out_illegal), 1);
    chk("mul_we", 32'(out_reg_we), 0);
`endif
    pop();
    send(32'h402081B3, 32'h50C);
    chk("sub_alu", 32'(out_alu_op), 1);
    chk("sub_we", 32'(out_reg_we), 1);
    pop();
    send(32'h042081B3, 32'h510);
    chk("badf7_ill", 32'(out_illegal), 1);
    pop();
    send(32'h00000073, 32'h514);
    chk("ecall_trap", 32'(out_trap), 1);
    chk("ecall_we", 32'(out_reg_we), 0);
    chk("ecall_ill", 32'(out_illegal), 0);
    pop();
    send(32'h00100073, 32'h518);
    chk("ebreak_trap", 32'(out_trap), 1);
    chk("ebreak_imm", out_imm, 1);
    pop();
    send(32'h008000EF, 32'h51C);
    chk("jal_jump", 32'(out_jump), 1);
    chk("jal_wb", 32'(out_wb_sel), 3);
    chk("jal_d1", 32'(out_d1_sel), 1);
    chk("jal_imm", out_imm, 8);
    chk("jal_rd", 32'(out_rd), 1);
    pop();
    send(32'h123453B7, 32'h520);
    chk("lui_wb", 32'(out_wb_sel), 2);
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_rd", 32'(out_rd), 7);
    pop();
    send(32'h00208863, 32'h524);
    chk("beq_cmp", 32'(out_cmp_op), 1);
    chk("beq_imm", out_imm, 16);
    chk("beq_we", 32'(out_reg_we), 0);
    pop();
    send(32'h0020A863, 32'h528);
    chk("br_f3_ill", 32'(out_illegal), 1);
    pop();
    send(32'h0000B003, 32'h52C);
    chk("ld_f3_ill", 32'(out_illegal), 1);
    pop();
    send(32'hFFF00290, 32'h530);
    chk("lowbits_ill", 32'(out_illegal), 1);
    pop();
    send(32'h0000000F, 32'h534);
    chk("fence_ill", 32'(out_illegal), 0);
    chk("fence_we", 32'(out_reg_we), 0);
    chk("fence_mem", 32'(out_mem_op), 0);
    pop();
    // mid-stream reset
    send(32'hFFF00293, 32'h600);
    send(32'hFFF00293, 32'h604);
    send(32'hFFF00293, 32'h608);
    chk("pre_rst_count", 32'(out_count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", 32'(out_count), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_valid", 32'(out_valid), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
